// File: rtl/l1d_pkg.sv
// Shared L1D request-bus definitions: op/size encodings, FSM states and the byte-enable helper.
// Reused by the MEM/WB stages and by the l1d_sram_resp responder.
package l1d_pkg;

    localparam logic [1:0] L1D_OP_RD = 2'b01;
    localparam logic [1:0] L1D_OP_WR = 2'b10;

    localparam int unsigned L1D_COP_CACHEABLE = 2;

    localparam logic [2:0] L1D_SZ_B = 3'b000;
    localparam logic [2:0] L1D_SZ_H = 3'b001;
    localparam logic [2:0] L1D_SZ_W = 3'b010;

    typedef enum logic [1:0] {
        L1D_ST_IDLE = 2'd0,
        L1D_ST_WAIT = 2'd1,
        L1D_ST_RESP = 2'd2
    } l1d_state_e;

    typedef struct packed {
        logic [2:0]  cop;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } l1d_req_t;

    // Lane mask for an access; halves align down to addr[1], reserved sizes select nothing.
    function automatic logic [3:0] l1d_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            L1D_SZ_B: be = 4'b0001 << addr_lo;
            L1D_SZ_H: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            L1D_SZ_W: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/l1d_sram_resp_if.sv
// L1D request/response bus between the MEM-stage initiator (master) and a responder (slave).
interface l1d_sram_resp_if;

    logic        l1d_req_val;
    logic        l1d_req_ack;
    logic [2:0]  l1d_req_cop;
    logic [2:0]  l1d_req_size;
    logic [31:0] l1d_req_addr;
    logic [31:0] l1d_req_wdata;
    logic        l1d_resp_val;
    logic [31:0] l1d_resp_rdata;
    logic        l1d_resp_err;
    logic        l1d_busy;

    modport master (
        output l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
        input  l1d_req_ack, l1d_resp_val, l1d_resp_rdata, l1d_resp_err, l1d_busy
    );

    modport slave (
        input  l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
        output l1d_req_ack, l1d_resp_val, l1d_resp_rdata, l1d_resp_err, l1d_busy
    );

endinterface

// File: rtl/l1d_sram_array.sv
// DEPTH x 32 word array with per-byte write enables and a registered read port.
// Read data is zero in any cycle following a non-read, so it can drive the response bus directly.
module l1d_sram_array #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[addr];
        else            rd_data <= '0;
    end

endmodule

// File: rtl/l1d_sram_resp.sv
// L1D bus responder: one outstanding request, LATENCY wait states, single-cycle response.
// Optional macro L1D_RESP_ERR_EN reports misaligned/reserved accesses on l1d_resp_err.
module l1d_sram_resp
    import l1d_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input logic            clk,
    input logic            rst,
    l1d_sram_resp_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    localparam logic [1:0] ST_IDLE = L1D_ST_IDLE;
    localparam logic [1:0] ST_WAIT = L1D_ST_WAIT;
    localparam logic [1:0] ST_RESP = L1D_ST_RESP;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    l1d_req_t      req_q, req_d;
    logic          ack_q, resp_val_q, busy_q;

    logic          op_ok, size_ok, access_ok, is_rd, is_wr, last_wait;
    logic [3:0]    arr_we;
    logic [31:0]   arr_wdata;
    logic          arr_rd;

    // Next-state and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.l1d_req_val) begin
                    req_d   = '{cop:   bus.l1d_req_cop,
                                size:  bus.l1d_req_size,
                                addr:  bus.l1d_req_addr,
                                wdata: bus.l1d_req_wdata};
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered off the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            ack_q      <= 1'b1;
            resp_val_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ack_q      <= (state_d == ST_IDLE);
            resp_val_q <= (state_d == ST_RESP);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign is_rd     = (req_q.cop[1:0] == L1D_OP_RD);
    assign is_wr     = (req_q.cop[1:0] == L1D_OP_WR);
    assign op_ok     = is_rd || is_wr;
    assign size_ok   = req_q.size inside {L1D_SZ_B, L1D_SZ_H, L1D_SZ_W};
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef L1D_RESP_ERR_EN
    logic misalign, err_c, err_q;
    assign misalign  = ((req_q.size == L1D_SZ_H) && req_q.addr[0]) ||
                       ((req_q.size == L1D_SZ_W) && (req_q.addr[1:0] != 2'b00));
    assign err_c     = !op_ok || !size_ok || misalign;
    assign access_ok = !err_c;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state_d == ST_RESP) && err_c;
    end
    assign bus.l1d_resp_err = err_q;
`else
    assign access_ok        = op_ok && size_ok;
    assign bus.l1d_resp_err = 1'b0;
`endif

    // Array access happens on the edge entering RESP; a reset on that edge cancels it.
    always_comb begin
        arr_we = 4'b0000;
        arr_rd = 1'b0;
        if (last_wait && access_ok && !rst) begin
            arr_we = is_wr ? l1d_byte_en(req_q.size, req_q.addr[1:0]) : 4'b0000;
            arr_rd = is_rd;
        end
    end

    always_comb begin
        case (req_q.size)
            L1D_SZ_B: arr_wdata = {4{req_q.wdata[7:0]}};
            L1D_SZ_H: arr_wdata = {2{req_q.wdata[15:0]}};
            default:  arr_wdata = req_q.wdata;
        endcase
    end

    l1d_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rst     (rst),
        .addr    (req_q.addr[AW+1:2]),
        .we      (arr_we),
        .wdata   (arr_wdata),
        .rd_en   (arr_rd),
        .rd_data (bus.l1d_resp_rdata)
    );

    // Cacheable flag and high address bits are carried but do not affect behaviour.
    logic unused_req;
    assign unused_req = ^{req_q.cop[L1D_COP_CACHEABLE], req_q.addr[31:AW+2]};

    assign bus.l1d_req_ack  = ack_q;
    assign bus.l1d_resp_val = resp_val_q;
    assign bus.l1d_busy     = busy_q;

endmodule

// File: tb/tb_l1d_sram_resp.sv
// Self-checking bench for l1d_sram_resp: directed vector table, multi-cycle corner sequences,
// and random traffic against a byte-level memory model. Honours L1D_RESP_ERR_EN if defined.
module tb_l1d_sram_resp;
    import l1d_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int          LAT   = 2;
`ifdef L1D_RESP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    localparam logic [2:0] C_RD  = 3'b001;
    localparam logic [2:0] C_WR  = 3'b010;
    localparam logic [2:0] CC_RD = 3'b101;
    localparam logic [2:0] CC_WR = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1d_sram_resp_if bus();

    l1d_sram_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [DEPTH*4];

    typedef struct {
        logic [2:0]  cop;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // One full transaction with accept, latency and pulse-width checks.
    task automatic do_req(input logic [2:0] cop, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int w;
        int lat;
        @(negedge clk);
        bus.l1d_req_val   = 1'b1;
        bus.l1d_req_cop   = cop;
        bus.l1d_req_size  = size;
        bus.l1d_req_addr  = addr;
        bus.l1d_req_wdata = wdata;
        w = 0;
        while (bus.l1d_req_ack !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ack_wait", 32'(bus.l1d_req_ack), 32'd1);
        @(negedge clk);
        bus.l1d_req_val = 1'b0;
        chk("ack_low", 32'(bus.l1d_req_ack), 32'd0);
        lat = 1;
        while (bus.l1d_resp_val !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT + 1));
        rd = bus.l1d_resp_rdata;
        er = bus.l1d_resp_err;
        @(negedge clk);
        chk("resp_pulse", 32'(bus.l1d_resp_val), 32'd0);
        chk("ack_back", 32'(bus.l1d_req_ack), 32'd1);
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned base;
        base = ((a / 4) % DEPTH) * 4;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_w;
        int          nacc, nresp, last;

        bus.l1d_req_val   = 1'b0;
        bus.l1d_req_cop   = '0;
        bus.l1d_req_size  = '0;
        bus.l1d_req_addr  = '0;
        bus.l1d_req_wdata = '0;

        vt[0]  = '{C_WR,  L1D_SZ_W, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{C_RD,  L1D_SZ_W, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{CC_WR, L1D_SZ_W, 32'h10,  32'h11223344, 32'h0,        1'b0};
        vt[3]  = '{C_WR,  L1D_SZ_B, 32'h13,  32'h000000AA, 32'h0,        1'b0};
        vt[4]  = '{C_RD,  L1D_SZ_W, 32'h10,  32'h0,        32'hAA223344, 1'b0};
        vt[5]  = '{C_WR,  L1D_SZ_H, 32'h12,  32'h00005566, 32'h0,        1'b0};
        vt[6]  = '{CC_RD, L1D_SZ_W, 32'h10,  32'h0,        32'h55663344, 1'b0};
        vt[7]  = '{C_RD,  L1D_SZ_B, 32'h11,  32'h0,        32'h55663344, 1'b0};
        vt[8]  = '{3'b000, L1D_SZ_W, 32'h10, 32'hFFFFFFFF, 32'h0,        ERR};
        vt[9]  = '{3'b011, L1D_SZ_W, 32'h10, 32'hFFFFFFFF, 32'h0,        ERR};
        vt[10] = '{C_RD,  3'b011,   32'h10,  32'h0,        32'h0,        ERR};
        vt[11] = '{C_WR,  3'b111,   32'h10,  32'hFFFFFFFF, 32'h0,        ERR};
        vt[12] = '{C_RD,  L1D_SZ_W, 32'h10,  32'h0,        32'h55663344, 1'b0};
        vt[13] = '{C_WR,  L1D_SZ_W, 32'(4*DEPTH+8), 32'hCAFEF00D, 32'h0, 1'b0};
        vt[14] = '{C_RD,  L1D_SZ_W, 32'h8,   32'h0,        32'hCAFEF00D, 1'b0};
        vt[15] = '{C_WR,  L1D_SZ_W, 32'h20,  32'h01020304, 32'h0,        1'b0};
        vt[16] = '{C_WR,  L1D_SZ_W, 32'h21,  32'hA5A5A5A5, 32'h0,        ERR};
        vt[17] = '{C_RD,  L1D_SZ_W, 32'h20,  32'h0, ERR ? 32'h01020304 : 32'hA5A5A5A5, 1'b0};
        vt[18] = '{C_WR,  L1D_SZ_H, 32'h13,  32'h0000BEEF, 32'h0,        ERR};
        vt[19] = '{C_RD,  L1D_SZ_W, 32'h10,  32'h0, ERR ? 32'h55663344 : 32'hBEEF3344, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   32'(bus.l1d_req_ack),  32'd1);
        chk("rst_rval",  32'(bus.l1d_resp_val), 32'd0);
        chk("rst_rdata", bus.l1d_resp_rdata,    32'd0);
        chk("rst_err",   32'(bus.l1d_resp_err), 32'd0);
        chk("rst_busy",  32'(bus.l1d_busy),     32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vt[i].cop, vt[i].size, vt[i].addr, vt[i].wdata, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
        end

        // val held high across three reads: one accept per LAT+2 cycles
        @(negedge clk);
        bus.l1d_req_val  = 1'b1;
        bus.l1d_req_cop  = C_RD;
        bus.l1d_req_size = L1D_SZ_W;
        bus.l1d_req_addr = 32'h10;
        nacc = 0; nresp = 0; last = -1;
        for (int c = 0; c < 3*(LAT+2); c++) begin
            if (bus.l1d_req_ack === 1'b1) begin
                if (last >= 0) chk("held_ack_spacing", 32'(c - last), 32'(LAT + 2));
                last = c;
                nacc++;
            end
            chk("held_busy_vs_ack", 32'(bus.l1d_busy), 32'(!bus.l1d_req_ack));
            if (bus.l1d_resp_val === 1'b1) begin
                nresp++;
                chk("held_rdata", bus.l1d_resp_rdata, vt[19].exp_rd);
            end
            @(negedge clk);
        end
        bus.l1d_req_val = 1'b0;
        chk("held_acks", 32'(nacc), 32'd3);
        chk("held_resps", 32'(nresp), 32'd3);

        // Reset during WAIT of a write drops the response and the write
        do_req(C_WR, L1D_SZ_W, 32'h20, 32'h0BADC0DE, rd, er);
        @(negedge clk);
        bus.l1d_req_val   = 1'b1;
        bus.l1d_req_cop   = C_WR;
        bus.l1d_req_size  = L1D_SZ_W;
        bus.l1d_req_addr  = 32'h20;
        bus.l1d_req_wdata = 32'h12345678;
        chk("rstw_ack", 32'(bus.l1d_req_ack), 32'd1);
        @(negedge clk);
        bus.l1d_req_val = 1'b0;
        rst = 1'b1;
        chk("rstw_busy_wait", 32'(bus.l1d_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_busy", 32'(bus.l1d_busy),     32'd0);
        chk("rstw_ack2", 32'(bus.l1d_req_ack),  32'd1);
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.l1d_resp_val === 1'b1) nresp++;
            @(negedge clk);
        end
        chk("rstw_no_resp", 32'(nresp), 32'd0);
        do_req(C_RD, L1D_SZ_W, 32'h20, 32'h0, rd, er);
        chk("rstw_old_data", rd, 32'h0BADC0DE);

        // Fill the whole array so the model knows every word
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_w = $urandom;
            do_req(C_WR, L1D_SZ_W, 32'(i*4), exp_w, rd, er);
            for (int k = 0; k < 4; k++) mb[i*4+k] = exp_w[8*k +: 8];
        end

        // Random traffic against the byte-level model
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  op;
            logic [2:0]  sz;
            logic [31:0] a, wd, exp_rd;
            logic        mis, legal, exp_err;
            int unsigned base, off, r, s;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? L1D_OP_RD : (r < 8) ? L1D_OP_WR : (r == 8) ? 2'b00 : 2'b11;
            s  = $urandom_range(0, 7);
            sz = (s < 2) ? L1D_SZ_B : (s < 4) ? L1D_SZ_H : (s < 7) ? L1D_SZ_W : 3'($urandom_range(3, 7));
            a  = 32'($urandom_range(0, DEPTH*16 - 1));
            wd = $urandom;
            mis     = (sz == L1D_SZ_H && a[0]) || (sz == L1D_SZ_W && a[1:0] != 2'b00);
            legal   = (op == L1D_OP_RD || op == L1D_OP_WR) && (sz <= 3'd2);
            exp_err = ERR && (!legal || mis);
            base    = ((a / 4) % DEPTH) * 4;
            exp_rd  = 32'h0;
            if (legal && !exp_err) begin
                if (op == L1D_OP_WR) begin
                    if (sz == L1D_SZ_B) begin
                        mb[base + a % 4] = wd[7:0];
                    end else if (sz == L1D_SZ_H) begin
                        off = ((a % 4) / 2) * 2;
                        mb[base + off]     = wd[7:0];
                        mb[base + off + 1] = wd[15:8];
                    end else begin
                        for (int k = 0; k < 4; k++) mb[base + k] = wd[8*k +: 8];
                    end
                end else begin
                    exp_rd = model_word(a);
                end
            end
            do_req({1'($urandom_range(0, 1)), op}, sz, a, wd, rd, er);
            if (!(ERR && mis && op == L1D_OP_RD))
                chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(exp_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
